// File: rtl/gpu_pkg.sv
// gpu_pkg: shared encodings for the GPU core slice.
//   CORE_FETCH / CORE_DECODE : core_state phase codes seen by the fetcher.
//   fetcher_state_e          : fetcher FSM states, exported on fetcher_state.
package gpu_pkg;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'b000,
    FS_FETCHING = 3'b001,
    FS_FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/lowest_set_pick.sv
// lowest_set_pick: priority picker, lowest set bit of a mask wins.
//   mask_i   : candidate mask
//   onehot_o : one-hot of the lowest set bit (zero when mask_i is zero)
//   index_o  : binary index of the lowest set bit (zero when mask_i is zero)
//   any_o    : mask_i has at least one bit set
module lowest_set_pick #(
  parameter int WIDTH    = 4,
  parameter int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    mask_i,
  output logic [WIDTH-1:0]    onehot_o,
  output logic [IDX_BITS-1:0] index_o,
  output logic                any_o
);

  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    any_o    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (mask_i[i] && !any_o) begin
        onehot_o[i] = 1'b1;
        index_o     = IDX_BITS'(i);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_fetcher.sv
// warp_fetcher: fetches one instruction per active thread of a warp from
// program memory, one request at a time, lowest-index pending thread first.
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   core_state        : core phase (CORE_FETCH starts a fetch, CORE_DECODE releases)
//   current_pc        : per-thread PC, thread t at [t*ADDR_BITS +: ADDR_BITS]
//   active_mask       : thread enables, snapshotted at the start of a fetch
//   mem_read_valid    : request valid (registered)
//   mem_read_address  : request address (registered)
//   mem_read_ready    : response valid, data on mem_read_data in the same cycle
//   mem_read_data     : instruction word
//   fetcher_state     : FS_IDLE / FS_FETCHING / FS_FETCHED
//   instruction       : per-thread fetched instruction, same packing as current_pc
//   req_count         : memory transactions used by the last fetch
// Build option: define FETCH_COALESCE_EN to let one response serve every
// pending thread whose current PC matches the outstanding address.
module warp_fetcher
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int THREADS   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     core_state,
  input  logic [THREADS*ADDR_BITS-1:0]   current_pc,
  input  logic [THREADS-1:0]             active_mask,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic [2:0]                     fetcher_state,
  output logic [THREADS*DATA_BITS-1:0]   instruction,
  output logic [$clog2(THREADS+1)-1:0]   req_count
);

  localparam int CW = $clog2(THREADS + 1);
  localparam int IW = (THREADS > 1) ? $clog2(THREADS) : 1;

  fetcher_state_e                 state_q, state_d;
  logic [THREADS-1:0]             pending_q, pending_d;
  logic                           valid_q, valid_d;
  logic [ADDR_BITS-1:0]           addr_q, addr_d;
  logic [THREADS*DATA_BITS-1:0]   instr_q, instr_d;
  logic [CW-1:0]                  count_q, count_d;

  logic [ADDR_BITS-1:0]           pc_arr [THREADS];
  logic [THREADS-1:0]             served;
  logic [THREADS-1:0]             remaining;
  logic [THREADS-1:0]             nxt_mask;

  logic [THREADS-1:0]             cur_oh;
  logic [IW-1:0]                  unused_cur_idx;
  logic                           cur_any;
  logic [THREADS-1:0]             unused_nxt_oh;
  logic [IW-1:0]                  nxt_idx;
  logic                           nxt_any;

  always_comb begin
    for (int unsigned t = 0; t < THREADS; t++) begin
      pc_arr[t] = current_pc[t*ADDR_BITS +: ADDR_BITS];
    end
  end

  // The pending mask does not change while a request waits for ready, so the
  // lowest pending thread now is the thread the outstanding request was formed for.
  lowest_set_pick #(.WIDTH(THREADS), .IDX_BITS(IW)) u_cur_pick (
    .mask_i   (pending_q),
    .onehot_o (cur_oh),
    .index_o  (unused_cur_idx),
    .any_o    (cur_any)
  );

  always_comb begin
    served = '0;
    if (state_q == FS_FETCHING && valid_q && mem_read_ready && cur_any) begin
      served = cur_oh;
`ifdef FETCH_COALESCE_EN
      for (int unsigned t = 0; t < THREADS; t++) begin
        if (pending_q[t] && pc_arr[t] == addr_q) begin
          served[t] = 1'b1;
        end
      end
`endif
    end
  end

  assign remaining = pending_q & ~served;

  // One picker forms both the first request (from the live mask in IDLE) and
  // each follow-on request (from what is left after the current response).
  assign nxt_mask = (state_q == FS_IDLE) ? active_mask : remaining;

  lowest_set_pick #(.WIDTH(THREADS), .IDX_BITS(IW)) u_nxt_pick (
    .mask_i   (nxt_mask),
    .onehot_o (unused_nxt_oh),
    .index_o  (nxt_idx),
    .any_o    (nxt_any)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    count_d   = count_q;
    case (state_q)
      FS_IDLE: begin
        if (core_state == CORE_FETCH) begin
          pending_d = active_mask;
          count_d   = '0;
          if (nxt_any) begin
            state_d = FS_FETCHING;
            valid_d = 1'b1;
            addr_d  = pc_arr[nxt_idx];
          end else begin
            state_d = FS_FETCHED;
          end
        end
      end
      FS_FETCHING: begin
        if (served != '0) begin
          for (int unsigned t = 0; t < THREADS; t++) begin
            if (served[t]) begin
              instr_d[t*DATA_BITS +: DATA_BITS] = mem_read_data;
            end
          end
          pending_d = remaining;
          count_d   = count_q + CW'(1);
          if (nxt_any) begin
            addr_d = pc_arr[nxt_idx];
          end else begin
            valid_d = 1'b0;
            state_d = FS_FETCHED;
          end
        end
      end
      FS_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = FS_IDLE;
        end
      end
      default: begin
        state_d   = FS_IDLE;
        valid_d   = 1'b0;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      instr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      count_q   <= count_d;
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign req_count        = count_q;

endmodule

// File: tb/tb_warp_fetcher.sv
module tb_warp_fetcher;
  import gpu_pkg::*;

  localparam int AB = 8;
  localparam int DB = 16;
  localparam int T  = 4;
  localparam int CW = $clog2(T + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        core_state;
  logic [T*AB-1:0]   current_pc;
  logic [T-1:0]      active_mask;
  logic              mem_read_valid;
  logic [AB-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DB-1:0]     mem_read_data;
  logic [2:0]        fetcher_state;
  logic [T*DB-1:0]   instruction;
  logic [CW-1:0]     req_count;

  warp_fetcher #(.ADDR_BITS(AB), .DATA_BITS(DB), .THREADS(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .active_mask      (active_mask),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .req_count        (req_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mem_delay = 1;

  typedef struct {
    logic [T*DB-1:0] instr;
    logic [CW-1:0]   cnt;
  } result_t;

  logic [AB-1:0] exp_addr_q[$];
  result_t       exp_res_q[$];

  // Memory contents: word at address a is {~a, a}.
  function automatic logic [DB-1:0] md(input logic [AB-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: raises ready after mem_delay waiting cycles per request.
  initial begin
    int wait_cnt;
    wait_cnt       = 0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !mem_read_valid) begin
        mem_read_ready = 1'b0;
        wait_cnt       = 0;
      end else begin
        if (mem_read_ready) wait_cnt = 0;
        if (wait_cnt >= mem_delay) begin
          mem_read_ready = 1'b1;
          mem_read_data  = md(mem_read_address);
        end else begin
          mem_read_ready = 1'b0;
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: checks each accepted request and each completed fetch.
  initial begin
    logic [AB-1:0] held_addr;
    bit            held;
    logic [2:0]    prev_fs;
    result_t       r;
    held      = 0;
    held_addr = '0;
    prev_fs   = 3'b000;
    forever begin
      @(negedge clk);
      if (reset) begin
        held    = 0;
        prev_fs = fetcher_state;
      end else begin
        if (mem_read_valid) begin
          if (held) check("addr_stable", mem_read_address, held_addr);
          if (mem_read_ready) begin
            if (exp_addr_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req: address %0h, expected no request", mem_read_address);
            end else begin
              check("req_addr", mem_read_address, exp_addr_q.pop_front());
            end
            held = 0;
          end else begin
            held      = 1;
            held_addr = mem_read_address;
          end
        end else begin
          if (held) begin
            checks++;
            errors++;
            $display("FAIL valid_dropped: valid 0 before ready, expected 1");
          end
          held = 0;
        end
        if (fetcher_state == FS_FETCHED && prev_fs != FS_FETCHED) begin
          if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetched: fetch completed, expected none");
          end else begin
            r = exp_res_q.pop_front();
            check("instruction", instruction, r.instr);
            check("req_count", req_count, r.cnt);
          end
        end
        prev_fs = fetcher_state;
      end
    end
  end

  task automatic run_fetch(input logic [T-1:0] mask, input logic [T*AB-1:0] pcs,
                           input int delay, input int hold, output int cyc);
    bit done;
    mem_delay = delay;
    @(posedge clk); #1;
    core_state  = CORE_FETCH;
    active_mask = mask;
    current_pc  = pcs;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      core_state  = 3'b100;
      active_mask = ~mask;
      if (fetcher_state == FS_FETCHED) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: state %0h after %0d cycles, expected FETCHED", fetcher_state, cyc);
    end
    for (int i = 0; i < hold; i++) begin
      core_state = CORE_FETCH;
      @(posedge clk); #1;
      check("fetched_hold", fetcher_state, FS_FETCHED);
    end
    core_state = CORE_DECODE;
    @(posedge clk); #1;
    check("decode_to_idle", fetcher_state, FS_IDLE);
    core_state = 3'b000;
  endtask

  initial begin
    int cyc;
    reset       = 1'b1;
    core_state  = 3'b000;
    current_pc  = '0;
    active_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", fetcher_state, FS_IDLE);
    check("rst_valid", mem_read_valid, 1'b0);
    check("rst_addr", mem_read_address, '0);
    check("rst_instr", instruction, '0);
    check("rst_count", req_count, '0);
    reset = 1'b0;

    // Four distinct PCs, one transaction each.
    exp_addr_q.push_back(8'd10);
    exp_addr_q.push_back(8'd11);
    exp_addr_q.push_back(8'd12);
    exp_addr_q.push_back(8'd13);
    exp_res_q.push_back('{64'hF20D_F30C_F40B_F50A, 3'd4});
    run_fetch(4'b1111, {8'd13, 8'd12, 8'd11, 8'd10}, 1, 0, cyc);

    // All threads at the same PC.
`ifdef FETCH_COALESCE_EN
    exp_addr_q.push_back(8'h20);
    exp_res_q.push_back('{64'hDF20_DF20_DF20_DF20, 3'd1});
`else
    repeat (4) exp_addr_q.push_back(8'h20);
    exp_res_q.push_back('{64'hDF20_DF20_DF20_DF20, 3'd4});
`endif
    run_fetch(4'b1111, {8'h20, 8'h20, 8'h20, 8'h20}, 1, 0, cyc);

    // Sparse mask: threads 0 and 2 keep their previous instructions.
    exp_addr_q.push_back(8'd6);
    exp_addr_q.push_back(8'd8);
    exp_res_q.push_back('{64'hF708_DF20_F906_DF20, 3'd2});
    run_fetch(4'b1010, {8'd8, 8'd7, 8'd6, 8'd5}, 1, 0, cyc);

    // Empty mask: FETCHED after one cycle, no request, held under FETCH.
    exp_res_q.push_back('{64'hF708_DF20_F906_DF20, 3'd0});
    run_fetch(4'b0000, {8'd4, 8'd3, 8'd2, 8'd1}, 1, 3, cyc);
    check("empty_latency", cyc, 1);

    // Ready withheld for five cycles.
    exp_addr_q.push_back(8'h33);
    exp_res_q.push_back('{64'hF708_DF20_F906_CC33, 3'd1});
    run_fetch(4'b0001, {8'h00, 8'h00, 8'h00, 8'h33}, 5, 0, cyc);

    // Reset in the middle of a transfer.
    mem_delay = 50;
    @(posedge clk); #1;
    core_state  = CORE_FETCH;
    active_mask = 4'b1111;
    current_pc  = {8'd4, 8'd3, 8'd2, 8'd1};
    @(posedge clk); #1;
    core_state = 3'b000;
    check("abort_valid_up", mem_read_valid, 1'b1);
    check("abort_addr", mem_read_address, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_state", fetcher_state, FS_IDLE);
    check("abort_valid", mem_read_valid, 1'b0);
    check("abort_addr0", mem_read_address, '0);
    check("abort_instr", instruction, '0);
    check("abort_count", req_count, '0);
    reset = 1'b0;
    exp_addr_q.delete();

    // Recovery with back-to-back ready.
    exp_addr_q.push_back(8'h44);
    exp_res_q.push_back('{64'h0000_BB44_0000_0000, 3'd1});
    run_fetch(4'b0100, {8'h00, 8'h44, 8'h00, 8'h00}, 0, 0, cyc);

    repeat (2) @(posedge clk);
    #1;
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("res_q_drained", exp_res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/warp_fetcher.md
WARP_FETCHER -- requirements
Module: warp_fetcher

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: program memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16: instruction width.
REQ-003 SHALL have parameter THREADS, default 4, legal range 1..32: threads per block.
REQ-004 SHALL have port clk  input  1: clock, rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port core_state  input  3: core phase; 3'b001 = FETCH, 3'b010 = DECODE.
REQ-007 SHALL have port current_pc  input  THREADS*ADDR_BITS: per-thread PC, thread t at bits [t*ADDR_BITS +: ADDR_BITS].
REQ-008 SHALL have port active_mask  input  THREADS: thread enables.
REQ-009 SHALL have port mem_read_valid  output  1: memory request valid.
REQ-010 SHALL have port mem_read_address  output  ADDR_BITS: request address.
REQ-011 SHALL have port mem_read_ready  input  1: response valid; data on mem_read_data in the same cycle.
REQ-012 SHALL have port mem_read_data  input  DATA_BITS: instruction word.
REQ-013 SHALL have port fetcher_state  output  3: IDLE = 000, FETCHING = 001, FETCHED = 010.
REQ-014 SHALL have port instruction  output  THREADS*DATA_BITS: per-thread fetched instruction, same packing as current_pc.
REQ-015 SHALL have port req_count  output  $clog2(THREADS+1): memory transactions used by the last fetch.

Function
REQ-016 In IDLE with core_state == FETCH, SHALL snapshot active_mask into an internal pending mask and clear req_count.
REQ-017 If the snapshot is all-zero, SHALL go to FETCHED next cycle, issue no request and leave every instruction unchanged.
REQ-018 Otherwise, SHALL enter FETCHING with mem_read_valid = 1 and mem_read_address = PC of the lowest-index pending thread, both registered (one cycle after the FETCH sample).
REQ-019 SHALL hold mem_read_valid and mem_read_address stable until a cycle with mem_read_ready = 1.
REQ-020 On the ready cycle, SHALL write mem_read_data into instruction of the served thread(s), clear those bits in the pending mask and increment req_count.
REQ-021 If pending bits remain after the ready cycle, SHALL present the next lowest-index pending PC on the following cycle with mem_read_valid still 1 (no idle gap).
REQ-022 If no pending bits remain after the ready cycle, SHALL drive mem_read_valid = 0 and move to FETCHED on the following cycle.
REQ-023 current_pc and active_mask changes during FETCHING SHALL be ignored for membership; the PC is sampled when each request is formed.
REQ-024 Instruction slots of threads not in the snapshot SHALL retain their previous value.
REQ-025 In FETCHED, SHALL return to IDLE on the cycle core_state == DECODE; otherwise SHALL hold.
REQ-026 core_state values other than FETCH/DECODE SHALL be ignored; an unused fetcher_state encoding SHALL return to IDLE next cycle.
REQ-027 mem_read_ready while mem_read_valid = 0 SHALL be ignored.

Reset
REQ-028 reset SHALL force, on the next edge and overriding any transfer in progress: fetcher_state = IDLE, mem_read_valid = 0, mem_read_address = 0, instruction = 0, req_count = 0, pending mask = 0.

Configuration
REQ-029 Macro FETCH_COALESCE_EN defined: on a ready cycle, every pending thread whose current PC equals mem_read_address SHALL receive the data and clear its bit, so one transaction serves all threads at that PC.
REQ-030 FETCH_COALESCE_EN undefined: each ready cycle SHALL serve only the single selected thread; req_count equals the snapshot popcount.

Structure
REQ-031 State encodings, core_state codes (FETCH, DECODE) and the fetcher state enum SHALL live in shared package gpu_pkg.
REQ-032 Lowest-index selection SHALL be a sub-module lowest_set_pick (THREADS-bit mask in; one-hot out plus index and any-set).

Verification
REQ-033 THREADS=4, mask 4'b1111, PCs 10/11/12/13, ready 1 cycle after each valid -> 4 transactions at addresses 10,11,12,13, each instruction = data returned for its address, req_count = 4.
REQ-034 COALESCE on, mask 4'b1111, all PCs = 0x20 -> one transaction, all four instructions equal, req_count = 1; COALESCE off -> 4 transactions to 0x20, req_count = 4.
REQ-035 Mask 4'b1010, PCs 5/6/7/8 -> requests to 6 then 8 only; instruction[0] and [2] unchanged.
REQ-036 Mask 4'b0000 at FETCH -> FETCHED after one cycle, mem_read_valid never 1, req_count = 0.
REQ-037 Ready withheld 5 cycles -> address and valid stable for all 5 cycles; reset asserted mid-FETCHING -> IDLE, valid 0, all instructions 0 on the next edge.
REQ-038 FETCHED with core_state held at FETCH for 3 cycles -> state held; core_state = DECODE -> IDLE on the next edge.
